// File: rtl/warp_tile_drain.sv
// warp_tile_drain
//   Consumer end of a warp's tile-output interface. Watches per-tile done
//   flags, captures completed tiles one at a time (lowest index first) into a
//   local TILE_WIDTH x TILE_HEIGHT buffer, and streams each tile as a
//   valid/ready pixel stream carrying warp-local pixel coordinates.
//
// Ports
//   clk, rst       clock; asynchronous active-low reset
//   enable         permits new tile captures (a tile in flight always finishes)
//   tile_in        warp tile data, indexed [tile][x][y]
//   tile_valid_in  per-tile done flags; a rising edge queues the tile
//   pix_valid/pix_ready/pix_data   pixel stream handshake and payload
//   pix_x, pix_y   warp-local pixel column/row of pix_data
//   pix_tile       index of the tile being streamed
//   pix_last       final pixel of the current tile
//   warp_done      one-cycle pulse after every NUM_TILES-th completed tile
//   busy           streaming, or at least one tile waiting

// Per-tile edge detector and pending flag.
module warp_tile_drain_flag (
   input  logic clk,
   input  logic rst,
   input  logic valid_in,
   input  logic clr,
   output logic pending
);
   logic valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         pending <= 1'b0;
      end else begin
         valid_q <= valid_in;
         // A new rise in the same cycle as this tile's capture re-queues it.
         if (valid_in & ~valid_q) pending <= 1'b1;
         else if (clr)            pending <= 1'b0;
      end
   end
endmodule

module warp_tile_drain #(
   parameter int WARP_WIDTH  = 8,
   parameter int WARP_HEIGHT = 8,
   parameter int TILE_WIDTH  = 8,
   parameter int TILE_HEIGHT = 8,
   parameter int NUM_TILES   = WARP_WIDTH * WARP_HEIGHT,
   parameter int COLORS      = 3,
   parameter int COLOR_DEPTH = 8,
   parameter int DATA_WIDTH  = COLORS * COLOR_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic [NUM_TILES-1:0][TILE_WIDTH-1:0][TILE_HEIGHT-1:0][DATA_WIDTH-1:0] tile_in,
   input  logic [NUM_TILES-1:0] tile_valid_in,
   output logic pix_valid,
   input  logic pix_ready,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic [$clog2(WARP_WIDTH*TILE_WIDTH)-1:0] pix_x,
   output logic [$clog2(WARP_HEIGHT*TILE_HEIGHT)-1:0] pix_y,
   output logic [$clog2(NUM_TILES)-1:0] pix_tile,
   output logic pix_last,
   output logic warp_done,
   output logic busy
);
   localparam int PXW = $clog2(WARP_WIDTH * TILE_WIDTH);
   localparam int PYW = $clog2(WARP_HEIGHT * TILE_HEIGHT);
   localparam int TIW = $clog2(NUM_TILES);
   localparam int XCW = (TILE_WIDTH  > 1) ? $clog2(TILE_WIDTH)  : 1;
   localparam int YCW = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
   localparam logic [XCW-1:0] X_LAST    = XCW'(TILE_WIDTH - 1);
   localparam logic [YCW-1:0] Y_LAST    = YCW'(TILE_HEIGHT - 1);
   localparam logic [TIW-1:0] DONE_LAST = TIW'(NUM_TILES - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                  state;
   logic [NUM_TILES-1:0]    pending;
   logic [NUM_TILES-1:0]    clr;
   logic [TIW-1:0]          sel;
   logic                    any_pend;
   logic                    accept;
   logic                    at_last;
   logic                    capture;
   logic [XCW-1:0]          x;
   logic [YCW-1:0]          y;
   logic [TIW-1:0]          done_cnt;
   logic [TILE_WIDTH-1:0][TILE_HEIGHT-1:0][DATA_WIDTH-1:0] tile_buf;

   // Edge detect + pending bit per tile.
   for (genvar i = 0; i < NUM_TILES; i++) begin : g_flag
      assign clr[i] = capture & (sel == TIW'(i));
      warp_tile_drain_flag u_flag (
         .clk      (clk),
         .rst      (rst),
         .valid_in (tile_valid_in[i]),
         .clr      (clr[i]),
         .pending  (pending[i])
      );
   end

   // Fixed priority: lowest pending index wins (scan high to low, last hit sticks).
   always_comb begin
      sel = '0;
      for (int i = NUM_TILES - 1; i >= 0; i--)
         if (pending[i]) sel = TIW'(i);
   end

   assign any_pend = |pending;
   assign accept   = pix_valid & pix_ready;
   assign at_last  = (x == X_LAST) & (y == Y_LAST);
   // Capture from IDLE, or straight off the last accepted pixel so back-to-back
   // tiles stream without a bubble.
   assign capture  = enable & any_pend & ((state == IDLE) | (accept & at_last));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         pix_tile  <= '0;
         tile_buf  <= '0;
         done_cnt  <= '0;
         warp_done <= 1'b0;
      end else begin
         warp_done <= 1'b0;
         if (accept & at_last) begin
            if (done_cnt == DONE_LAST) begin
               done_cnt  <= '0;
               warp_done <= 1'b1;
            end else begin
               done_cnt  <= done_cnt + 1'b1;
            end
         end

         if (capture) begin
            state    <= STREAM;
            tile_buf <= tile_in[sel];
            pix_tile <= sel;
            x        <= '0;
            y        <= '0;
         end else if (accept) begin
            if (at_last) state <= IDLE;
            if (x == X_LAST) begin
               x <= '0;
               y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end
      end
   end

   // All outputs come straight from registers, so they hold while stalled.
   assign pix_valid = (state == STREAM);
   assign pix_last  = pix_valid & at_last;
   assign pix_data  = tile_buf[x][y];
   assign pix_x     = PXW'((int'(pix_tile) % WARP_WIDTH) * TILE_WIDTH + int'(x));
   assign pix_y     = PYW'((int'(pix_tile) / WARP_WIDTH) * TILE_HEIGHT + int'(y));
   assign busy      = pix_valid | any_pend;

endmodule

// File: tb/tb_warp_tile_drain.sv
// Directed + randomized bench for warp_tile_drain. The reference model is a
// queue of tile indices in expected stream order plus a running pixel index;
// expected pixel values and coordinates are computed arithmetically.
module tb_warp_tile_drain;
   localparam int WW = 8, WH = 8, TW = 8, TH = 8, NT = 64, DW = 24;
   localparam int NPIX = TW * TH;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic [NT-1:0][TW-1:0][TH-1:0][DW-1:0] tile_in;
   logic [NT-1:0] tile_valid_in;
   logic          pix_valid, pix_ready, pix_last, warp_done, busy;
   logic [DW-1:0] pix_data;
   logic [5:0]    pix_x, pix_y, pix_tile;

   warp_tile_drain dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .tile_in       (tile_in),
      .tile_valid_in (tile_valid_in),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .pix_data      (pix_data),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .pix_tile      (pix_tile),
      .pix_last      (pix_last),
      .warp_done     (warp_done),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int            vectors = 0;
   int            miscompares = 0;
   int            exp_q[$];
   int            pidx = 0;
   int            done_m = 0;
   logic [DW-1:0] salt;

   function automatic logic [DW-1:0] exp_pix(input int t, input int px, input int py);
      return {8'(t), 8'(px), 8'(py)} ^ salt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic raise_mask(input logic [NT-1:0] m);
      for (int i = 0; i < NT; i++)
         if (m[i]) begin
            tile_valid_in[i] = 1'b1;
            exp_q.push_back(i);
         end
   endtask

   task automatic raise_one(input int i);
      logic [NT-1:0] m;
      m = '0;
      m[i] = 1'b1;
      raise_mask(m);
   endtask

   // Stream against the model until the queue empties or max_acc accepts.
   task automatic drain(input int max_acc, input bit rnd, input bit nobub, input int budget);
      int acc = 0;
      int ncyc = 0;
      bit started = 0;
      bit held = 0;
      bit done_nxt;
      int t, px, py;
      logic [DW-1:0] h_data;
      logic [5:0] h_x, h_y, h_t;
      logic h_last;
      while (exp_q.size() > 0 && acc < max_acc) begin
         if (ncyc >= budget) begin
            chk("drain_timeout_tiles_left", exp_q.size(), 0);
            break;
         end
         pix_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (held) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, h_data);
            chk("stall_x", pix_x, h_x);
            chk("stall_y", pix_y, h_y);
            chk("stall_tile", pix_tile, h_t);
            chk("stall_last", pix_last, h_last);
         end
         if (nobub && started) chk("no_bubble", pix_valid, 1);
         done_nxt = 1'b0;
         if (pix_valid === 1'b1) started = 1;
         if (pix_valid === 1'b1 && pix_ready) begin
            t  = exp_q[0];
            px = pidx % TW;
            py = pidx / TW;
            chk("pix_tile", pix_tile, t);
            chk("pix_data", pix_data, exp_pix(t, px, py));
            chk("pix_x", pix_x, (t % WW) * TW + px);
            chk("pix_y", pix_y, (t / WW) * TH + py);
            chk("pix_last", pix_last, (pidx == NPIX - 1) ? 1 : 0);
            pidx++;
            acc++;
            held = 0;
            if (pidx == NPIX) begin
               pidx = 0;
               void'(exp_q.pop_front());
               done_m++;
               if (done_m == NT) begin
                  done_m   = 0;
                  done_nxt = 1'b1;
               end
            end
         end else if (pix_valid === 1'b1) begin
            held = 1;
            h_data = pix_data; h_x = pix_x; h_y = pix_y; h_t = pix_tile; h_last = pix_last;
         end else begin
            held = 0;
         end
         step();
         chk("warp_done", warp_done, done_nxt);
         ncyc++;
      end
      pix_ready = 1'b1;
   endtask

   task automatic idle_check(input string tag, input int n, input bit exp_busy);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, pix_valid, 0);
         chk({tag, "_busy"}, busy, exp_busy);
         step();
      end
   endtask

   initial begin
      logic [NT-1:0] m;
      salt          = 24'($urandom);
      rst           = 1'b0;
      enable        = 1'b1;
      pix_ready     = 1'b1;
      tile_valid_in = '0;
      for (int t = 0; t < NT; t++)
         for (int x = 0; x < TW; x++)
            for (int y = 0; y < TH; y++)
               tile_in[t][x][y] = exp_pix(t, x, y);

      // Reset state
      step(); step();
      chk("rst_valid", pix_valid, 0);
      chk("rst_last", pix_last, 0);
      chk("rst_done", warp_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", pix_data, 0);
      chk("rst_x", pix_x, 0);
      chk("rst_y", pix_y, 0);
      chk("rst_tile", pix_tile, 0);
      rst = 1'b1;
      step();

      // Single tile 9: valid two edges after the rise
      raise_one(9);
      step();
      chk("t9_lat_valid0", pix_valid, 0);
      chk("t9_lat_busy", busy, 1);
      step();
      chk("t9_lat_valid1", pix_valid, 1);
      chk("t9_first_x", pix_x, 8);
      chk("t9_first_y", pix_y, 8);
      drain(1 << 30, 0, 1, NPIX + 10);
      idle_check("t9_after", 2, 0);
      tile_valid_in = '0;
      step();

      // Priority and zero bubbles: 5, 2, 40 together -> 2, 5, 40
      m = '0; m[5] = 1'b1; m[2] = 1'b1; m[40] = 1'b1;
      raise_mask(m);
      drain(1 << 30, 0, 1, 3 * NPIX + 10);
      idle_check("prio_after", 2, 0);
      tile_valid_in = '0;
      step();

      // Backpressure on tile 0
      raise_one(0);
      drain(1 << 30, 1, 0, 6 * NPIX);
      idle_check("bp_after", 3, 0);
      tile_valid_in = '0;
      step();

      // Enable gating
      enable = 1'b0;
      raise_one(3);
      step();
      idle_check("en_blocked", 3, 1);
      enable = 1'b1;
      step();
      chk("en_capture_valid", pix_valid, 1);
      chk("en_capture_tile", pix_tile, 3);
      enable = 1'b0;
      tile_valid_in[4] = 1'b1;
      drain(1 << 30, 0, 0, NPIX + 10);
      idle_check("en_t4_waits", 3, 1);
      enable = 1'b1;
      exp_q.push_back(4);
      step();
      chk("en_t4_valid", pix_valid, 1);
      drain(1 << 30, 0, 0, NPIX + 10);
      tile_valid_in = '0;
      step();

      // Reset mid-stream at pixel 20 of tile 7
      raise_one(7);
      drain(20, 0, 0, 40);
      chk("mid_pre_tile", pix_tile, 7);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", pix_valid, 0);
      chk("mid_rst_last", pix_last, 0);
      chk("mid_rst_data", pix_data, 0);
      chk("mid_rst_x", pix_x, 0);
      chk("mid_rst_y", pix_y, 0);
      chk("mid_rst_tile", pix_tile, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", warp_done, 0);
      exp_q.delete();
      pidx   = 0;
      done_m = 0;
      step();
      rst = 1'b1;
      exp_q.push_back(7);
      step();
      chk("mid_requeue_valid0", pix_valid, 0);
      chk("mid_requeue_busy", busy, 1);
      drain(1 << 30, 0, 0, NPIX + 10);
      tile_valid_in = '0;
      step();

      // Full warp from a fresh done count
      rst = 1'b0;
      step();
      rst = 1'b1;
      done_m = 0;
      step();
      raise_mask('1);
      drain(1 << 30, 0, 1, NT * NPIX + 20);
      step();
      chk("warp_done_one_cycle", warp_done, 0);
      idle_check("warp_after", 2, 0);
      tile_valid_in = '0;
      step();

      // Random tile sets with random backpressure; done count continues from 0
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NT; i++) m[i] = ($urandom_range(0, 9) == 0);
         if (m == '0) m[$urandom_range(0, NT - 1)] = 1'b1;
         raise_mask(m);
         drain(1 << 30, 1, 0, NT * NPIX * 4);
         idle_check("rand_after", 2, 0);
         tile_valid_in = '0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/warp_tile_drain.md
# warp_tile_drain

Consumer end of the warp tile-output interface. Watches the per-tile `tile_valid` flags and the `tile_out` array produced by a warp. Captures completed tiles one at a time into a local 8x8 pixel buffer and streams them as a single valid/ready pixel stream with warp-local x/y coordinates, toward the framebuffer writer. Sits between a warp instance and the framebuffer write port.

## Interface
- `WARP_WIDTH`, 8, tiles per warp row
- `WARP_HEIGHT`, 8, tiles per warp column
- `TILE_WIDTH`, 8, pixels per tile row
- `TILE_HEIGHT`, 8, pixels per tile column
- `NUM_TILES`, WARP_WIDTH*WARP_HEIGHT, tiles per warp
- `COLORS`, 3, color channels per pixel
- `COLOR_DEPTH`, 8, bits per channel
- `DATA_WIDTH`, COLORS*COLOR_DEPTH, pixel width
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  permits new tile captures
- `tile_in`  in  DATA_WIDTH x [NUM_TILES][TILE_WIDTH][TILE_HEIGHT]  warp tile data, indexed [tile][x][y]
- `tile_valid_in`  in  1 x [NUM_TILES]  per-tile done flags from the warp
- `pix_valid`  out  1  pixel stream valid
- `pix_ready`  in  1  downstream accepts the pixel
- `pix_data`  out  DATA_WIDTH  pixel value
- `pix_x`  out  $clog2(WARP_WIDTH*TILE_WIDTH)  warp-local pixel column
- `pix_y`  out  $clog2(WARP_HEIGHT*TILE_HEIGHT)  warp-local pixel row
- `pix_tile`  out  $clog2(NUM_TILES)  index of the tile being streamed
- `pix_last`  out  1  marks the final pixel of a tile
- `warp_done`  out  1  one-cycle pulse after the NUM_TILES-th tile completes
- `busy`  out  1  high in STREAM or when any tile is pending

## Operation
- **Edge detect.** `valid_q[i]` registers `tile_valid_in[i]`. Reset value is 0, so a flag that is already high after reset release counts as a rising edge.
- **Pending.** `pending[i]` sets on the rise (`tile_valid_in[i] & ~valid_q[i]`). It clears when the tile is captured. If a rise and a capture of the same tile occur in the same cycle, set wins and the tile is re-queued.
- **Selection.** The lowest-index pending tile is selected (fixed priority).
- **States:**
  - IDLE: if `enable` and any pending, capture the selected tile and go to STREAM. Otherwise stay in IDLE.
  - STREAM: present pixel (x,y) from the buffer. Advance on `pix_valid & pix_ready`. Order is raster: x inner 0..TILE_WIDTH-1, then y outer 0..TILE_HEIGHT-1.
  - On the last pixel accepted: if `enable` and any pending, capture the next tile and remain in STREAM with no bubble. Otherwise go to IDLE.
- **Capture.**
  - Copies `tile_in[sel]` (all 64 pixels) into the local buffer in one cycle.
  - Latches `pix_tile` = sel and resets the x/y counters to 0.
  - Samples `tile_in` regardless of the current `tile_valid_in` level. Upstream holds tile data stable from the rise until capture.
- **Coordinates.**
  - `pix_x` = (pix_tile % WARP_WIDTH)*TILE_WIDTH + x
  - `pix_y` = (pix_tile / WARP_WIDTH)*TILE_HEIGHT + y
  - Computed at full output width, no overflow with default parameters.
- **`pix_last`** = STREAM & x==TILE_WIDTH-1 & y==TILE_HEIGHT-1.
- **Done counter.**
  - Increments on each accepted `pix_last`.
  - On the accept that reaches NUM_TILES: `warp_done` pulses the next cycle and the counter wraps to 0.
  - Duplicate re-queued tiles also count.
- **`enable` low.**
  - Blocks captures only. A tile in progress streams to completion.
  - Pending bits keep accumulating.

## Timing
- Reset (async assert, sync release):
  - `pix_valid`, `pix_last`, `warp_done` = 0; `busy` = 0
  - `pix_data`, `pix_x`, `pix_y`, `pix_tile` = 0
  - pending = 0, `valid_q` = 0, done counter = 0, state = IDLE
- Reset asserted mid-stream aborts the tile immediately. The partial tile is lost and is not re-queued.
- Latency:
  - Rise of `tile_valid_in` sampled at edge k sets pending after edge k.
  - Capture happens at edge k+1 when idle; `pix_valid` is high after edge k+1.
- Throughput: one pixel per cycle with `pix_ready` high. A tile takes TILE_WIDTH*TILE_HEIGHT = 64 cycles. Back-to-back tiles have zero bubbles.
- Handshake rules:
  - While `pix_valid` is high and `pix_ready` is low, `pix_data`, `pix_x`, `pix_y`, `pix_tile` and `pix_last` are held stable.
  - `pix_valid` never drops without an accept, except on reset.

## Test plan
- **Single tile.** Reset, then raise `tile_valid_in[9]` with pixel (x,y) = {tile 9, x, y}, `pix_ready`=1. Expect:
  - `pix_valid` two cycles after the rise, followed by 64 pixels.
  - First pixel: `pix_x`=8, `pix_y`=8.
  - Last pixel: `pix_x`=15, `pix_y`=15, with `pix_last`=1.
  - Then IDLE and `busy`=0.
- **Priority and no bubbles.** Raise tiles 5, 2 and 40 in the same cycle. Expect streaming order 2, 5, 40 with `pix_valid` continuously high for 192 cycles.
- **Backpressure.** Toggle `pix_ready` pseudo-randomly during tile 0. Expect outputs stable while stalled and exactly 64 accepts, pixel order unchanged.
- **Full warp.** Raise all 64 flags. Expect 4096 accepts and a `warp_done` pulse of exactly 1 cycle after the final `pix_last` accept. The counter then restarts from 0.
- **Enable gating.** With `enable`=0, raise tile 3. Expect no `pix_valid` and `busy`=1. Set `enable`=1: capture the next cycle. Drop `enable` mid-tile: the tile completes and a pending tile 4 waits.
- **Reset mid-stream.** Pull `rst` low at pixel 20 of tile 7. Expect all outputs 0 immediately and pending cleared. After release, with `tile_valid_in[7]` still high, tile 7 streams again from pixel 0.
